// File: rtl/axil_mux_wr.sv
// AXI-Lite write-path multiplexer.
// The block latches the arbiter's grant and steers the AW, W and B channels of
// the granted master onto the single slave port. It holds that path until the
// write response is accepted, then pulses wr_done.
module axil_mux_wr #(
   parameter int NUMBER_MASTER = 2,
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   localparam int GW = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1,
   localparam int SW = DATA_WIDTH / 8
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic                              grant_valid,
   input  logic [GW-1:0]                     grant_wr,
   output logic                              busy,
   output logic                              wr_done,
   input  logic [NUMBER_MASTER*ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [NUMBER_MASTER*3-1:0]        s_axil_awprot,
   input  logic [NUMBER_MASTER-1:0]          s_axil_awvalid,
   output logic [NUMBER_MASTER-1:0]          s_axil_awready,
   input  logic [NUMBER_MASTER*DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [NUMBER_MASTER*SW-1:0]       s_axil_wstrb,
   input  logic [NUMBER_MASTER-1:0]          s_axil_wvalid,
   output logic [NUMBER_MASTER-1:0]          s_axil_wready,
   output logic [1:0]                        s_axil_bresp,
   output logic [NUMBER_MASTER-1:0]          s_axil_bvalid,
   input  logic [NUMBER_MASTER-1:0]          s_axil_bready,
   output logic [ADDR_WIDTH-1:0]             m_axil_awaddr,
   output logic [2:0]                        m_axil_awprot,
   output logic                              m_axil_awvalid,
   input  logic                              m_axil_awready,
   output logic [DATA_WIDTH-1:0]             m_axil_wdata,
   output logic [SW-1:0]                     m_axil_wstrb,
   output logic                              m_axil_wvalid,
   input  logic                              m_axil_wready,
   input  logic [1:0]                        m_axil_bresp,
   input  logic                              m_axil_bvalid,
   output logic                              m_axil_bready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [GW-1:0]   sel_reg, sel_next;
   logic            aw_done_reg, aw_done_next;
   logic            w_done_reg, w_done_next;
   logic            wr_done_reg, wr_done_next;
   logic            busy_reg, busy_next;

   logic [ADDR_WIDTH-1:0] awaddr_sel;
   logic [2:0]            awprot_sel;
   logic                  awvalid_sel;
   logic [DATA_WIDTH-1:0] wdata_sel;
   logic [SW-1:0]         wstrb_sel;
   logic                  wvalid_sel;
   logic                  bready_sel;

   logic [31:0] grant_ext;
   logic        grant_ok;
   logic        in_xfer, in_resp;
   logic        aw_hs, w_hs, b_hs;

   // Grants naming a master that does not exist (possible when NUMBER_MASTER
   // is not a power of two) must be dropped.
   assign grant_ext = 32'(grant_wr);
   assign grant_ok  = (grant_ext < 32'(NUMBER_MASTER));

   assign in_xfer = (state_reg == XFER);
   assign in_resp = (state_reg == RESP);

   // Pick out the granted master's request signals; zero when no master matches.
   always_comb begin
      awaddr_sel  = '0;
      awprot_sel  = '0;
      awvalid_sel = 1'b0;
      wdata_sel   = '0;
      wstrb_sel   = '0;
      wvalid_sel  = 1'b0;
      bready_sel  = 1'b0;
      for (int i = 0; i < NUMBER_MASTER; i++) begin
         if (sel_reg == GW'(i)) begin
            awaddr_sel  = s_axil_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            awprot_sel  = s_axil_awprot[i*3 +: 3];
            awvalid_sel = s_axil_awvalid[i];
            wdata_sel   = s_axil_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            wstrb_sel   = s_axil_wstrb[i*SW +: SW];
            wvalid_sel  = s_axil_wvalid[i];
            bready_sel  = s_axil_bready[i];
         end
      end
   end

   // Slave-side request channels. These are live only in XFER, and each is
   // muted once its handshake has completed.
   assign m_axil_awvalid = in_xfer & awvalid_sel & ~aw_done_reg;
   assign m_axil_wvalid  = in_xfer & wvalid_sel & ~w_done_reg;
   assign m_axil_awaddr  = in_xfer ? awaddr_sel : '0;
   assign m_axil_awprot  = in_xfer ? awprot_sel : '0;
   assign m_axil_wdata   = in_xfer ? wdata_sel : '0;
   assign m_axil_wstrb   = in_xfer ? wstrb_sel : '0;
   assign m_axil_bready  = in_resp & bready_sel;
   assign s_axil_bresp   = in_resp ? m_axil_bresp : 2'b00;

   // Only the selected master ever sees ready or response valid.
   generate
      for (genvar gi = 0; gi < NUMBER_MASTER; gi++) begin : g_master
         localparam logic [GW-1:0] IDX = GW'(gi);
         logic hit;
         assign hit               = (sel_reg == IDX);
         assign s_axil_awready[gi] = in_xfer & hit & m_axil_awready & ~aw_done_reg;
         assign s_axil_wready[gi]  = in_xfer & hit & m_axil_wready & ~w_done_reg;
         assign s_axil_bvalid[gi]  = in_resp & hit & m_axil_bvalid;
      end
   endgenerate

   assign aw_hs = m_axil_awvalid & m_axil_awready;
   assign w_hs  = m_axil_wvalid & m_axil_wready;
   assign b_hs  = m_axil_bready & m_axil_bvalid;

   // Next-state logic: grant capture, per-channel completion tracking, response hold.
   always_comb begin
      state_next   = state_reg;
      sel_next     = sel_reg;
      aw_done_next = aw_done_reg;
      w_done_next  = w_done_reg;
      wr_done_next = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (grant_valid && grant_ok) begin
               sel_next     = grant_wr;
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               state_next   = XFER;
            end
         end
         XFER: begin
            aw_done_next = aw_done_reg | aw_hs;
            w_done_next  = w_done_reg | w_hs;
            if (aw_done_next && w_done_next) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (b_hs) begin
               state_next   = IDLE;
               wr_done_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   // State and flag registers; reset aborts any transaction in flight.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_reg   <= IDLE;
         sel_reg     <= '0;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         wr_done_reg <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         sel_reg     <= sel_next;
         aw_done_reg <= aw_done_next;
         w_done_reg  <= w_done_next;
         wr_done_reg <= wr_done_next;
         busy_reg    <= busy_next;
      end
   end

   assign busy    = busy_reg;
   assign wr_done = wr_done_reg;

endmodule
